// File: rtl/ready_flop.sv
// ready_flop: backward-path register slice; ready_up is a pure flop, with a one-entry skid register.
// Latency: zero on the forward path. valid_down and data_down pass through combinationally while the skid is empty.
// Backpressure: a beat accepted while ready_down is low parks in the skid and ready_up drops the next cycle.
// Optional stall counter is enabled by the READY_FLOP_STALL_CNT_EN macro.
module ready_flop #(
    parameter int width = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_up,
    input  logic [width-1:0] data_up,
    input  logic             ready_down,
    output logic             ready_up,
    output logic             valid_down,
    output logic [width-1:0] data_down
`ifdef READY_FLOP_STALL_CNT_EN
    ,
    input  logic             stall_clr,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [1:0] INIT = 2'd0;
    localparam logic [1:0] PASS = 2'd1;
    localparam logic [1:0] SKID = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             ready_nxt;
    logic [width-1:0] skid_data;
    logic [width-1:0] skid_nxt;

    always_comb begin
        state_nxt = state;
        ready_nxt = ready_up;
        skid_nxt  = skid_data;
        case (state)
            INIT: begin
                state_nxt = PASS;
                ready_nxt = 1'b1;
            end
            PASS: begin
                // The upstream saw ready_up=1, so this beat is ours even though downstream refused it.
                if (valid_up && !ready_down) begin
                    state_nxt = SKID;
                    ready_nxt = 1'b0;
                    skid_nxt  = data_up;
                end
            end
            SKID: begin
                if (ready_down) begin
                    state_nxt = PASS;
                    ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = INIT;
                ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            ready_up  <= 1'b0;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            ready_up  <= ready_nxt;
            skid_data <= skid_nxt;
        end
    end

    always_comb begin
        valid_down = 1'b0;
        data_down  = skid_data;
        case (state)
            PASS: begin
                valid_down = valid_up;
                data_down  = data_up;
            end
            SKID: begin
                valid_down = 1'b1;
                data_down  = skid_data;
            end
            default: begin
                valid_down = 1'b0;
                data_down  = skid_data;
            end
        endcase
    end

`ifdef READY_FLOP_STALL_CNT_EN
    logic stall_evt;
    assign stall_evt = valid_down && !ready_down;

    // Clear wins over increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
